// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes shared by the light controller and the queue sensor
package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t LIGHT_GREEN   = 2'b00;
  localparam light_t LIGHT_YELLOW  = 2'b01;
  localparam light_t LIGHT_RED     = 2'b10;
  localparam light_t LIGHT_ILLEGAL = 2'b11;

endpackage

// File: rtl/queue_lane.sv
// rtl/queue_lane.sv - one street: detector sync/edge, departure timer, saturating queue count
module queue_lane
  import traffic_pkg::*;
#(
  parameter int QW         = 4,
  parameter int DEPART_CYC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          car_raw,
  input  logic [1:0]    light,
  output logic [QW-1:0] q,
  output logic          ovf
);

  localparam int            TW     = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DEPART_CYC - 1);
  localparam logic [QW-1:0] Q_MAX  = '1;

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [TW-1:0] timer;
  logic          arrival;
  logic          advance;
  logic          depart;

  assign arrival = sync2 & ~prev;
  // Yellow, red and the illegal code all freeze draining.
  assign advance = (light == LIGHT_GREEN) && (q != '0);
  assign depart  = advance && (timer == T_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      timer <= '0;
      q     <= '0;
      ovf   <= 1'b0;
    end else begin
      sync1 <= car_raw;
      sync2 <= sync1;
      prev  <= sync2;

      if (!advance || depart) timer <= '0;
      else                    timer <= timer + 1'b1;

      // A coincident arrival and departure cancel, even at saturation.
      if (arrival && !depart) begin
        if (q == Q_MAX) ovf <= 1'b1;
        else            q   <= q + 1'b1;
      end else if (depart && !arrival) begin
        q <= q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_queue_sensor.sv
// rtl/traffic_queue_sensor.sv - per-street queue counts and traffic-present flags for the light controller
module traffic_queue_sensor
  import traffic_pkg::*;
#(
  parameter int QW         = 4,
  parameter int DEPART_CYC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          carA_raw,
  input  logic          carB_raw,
  input  logic [1:0]    LA,
  input  logic [1:0]    LB,
  output logic          TA,
  output logic          TB,
  output logic [QW-1:0] QA,
  output logic [QW-1:0] QB,
  output logic          ovfA,
  output logic          ovfB,
  output logic          err
);

  queue_lane #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_lane_a (
    .clk     (clk),
    .rst     (rst),
    .car_raw (carA_raw),
    .light   (LA),
    .q       (QA),
    .ovf     (ovfA)
  );

  queue_lane #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_lane_b (
    .clk     (clk),
    .rst     (rst),
    .car_raw (carB_raw),
    .light   (LB),
    .q       (QB),
    .ovf     (ovfB)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (LA == LIGHT_ILLEGAL || LB == LIGHT_ILLEGAL ||
                 (LA == LIGHT_GREEN && LB == LIGHT_GREEN)) begin
      err <= 1'b1;
    end
  end

  assign TA = (QA != '0);
  assign TB = (QB != '0);

endmodule

// File: tb/tb_traffic_queue_sensor.sv
// tb/tb_traffic_queue_sensor.sv - directed and randomized checks of traffic_queue_sensor against a cycle model
module tb_traffic_queue_sensor;

  localparam int QW         = 4;
  localparam int DEPART_CYC = 3;
  localparam int Q_MAX      = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          car_a;
  logic          car_b;
  logic [1:0]    la;
  logic [1:0]    lb;
  logic          ta;
  logic          tb;
  logic [QW-1:0] qa;
  logic [QW-1:0] qb;
  logic          ovf_a;
  logic          ovf_b;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  int q_m[2];
  int run_m[2];
  bit ovf_m[2];
  bit hist_m[2][4];
  bit err_m;

  traffic_queue_sensor #(.QW(QW), .DEPART_CYC(DEPART_CYC)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .carA_raw (car_a),
    .carB_raw (car_b),
    .LA       (la),
    .LB       (lb),
    .TA       (ta),
    .TB       (tb),
    .QA       (qa),
    .QB       (qb),
    .ovfA     (ovf_a),
    .ovfB     (ovf_b),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < 2; l++) begin
      q_m[l]   = 0;
      run_m[l] = 0;
      ovf_m[l] = 1'b0;
      for (int k = 0; k < 4; k++) hist_m[l][k] = 1'b0;
    end
    err_m = 1'b0;
  endtask

  // One clock edge: a car counts when the raw level seen two edges ago is high
  // and the level seen three edges ago is low; a car leaves after every
  // DEPART_CYC consecutive green cycles with a nonempty queue.
  task automatic model_edge();
    bit raw[2];
    int lt[2];
    bit arr;
    bit dep;
    bit busy;
    raw[0] = car_a;
    raw[1] = car_b;
    lt[0]  = la;
    lt[1]  = lb;
    if (!rst_n) begin
      model_clear();
    end else begin
      if (la == 2'b11 || lb == 2'b11 || (la == 2'b00 && lb == 2'b00)) err_m = 1'b1;
      for (int l = 0; l < 2; l++) begin
        for (int k = 3; k > 0; k--) hist_m[l][k] = hist_m[l][k-1];
        hist_m[l][0] = raw[l];
        arr  = hist_m[l][2] && !hist_m[l][3];
        busy = (lt[l] == 0) && (q_m[l] != 0);
        run_m[l] = busy ? run_m[l] + 1 : 0;
        dep  = busy && (run_m[l] % DEPART_CYC == 0);
        if (arr && !dep) begin
          if (q_m[l] == Q_MAX) ovf_m[l] = 1'b1;
          else                 q_m[l]++;
        end else if (dep && !arr) begin
          q_m[l]--;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("QA",   qa,    q_m[0]);
    check("QB",   qb,    q_m[1]);
    check("TA",   ta,    int'(q_m[0] != 0));
    check("TB",   tb,    int'(q_m[1] != 0));
    check("ovfA", ovf_a, ovf_m[0]);
    check("ovfB", ovf_b, ovf_m[1]);
    check("err",  err,   err_m);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic pulse(input int lane, input int hi, input int lo);
    if (lane == 0) car_a = 1'b1; else car_b = 1'b1;
    repeat (hi) step();
    if (lane == 0) car_a = 1'b0; else car_b = 1'b0;
    repeat (lo) step();
  endtask

  // Drops reset between edges and checks the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check({tag, "_QA"},  qa,  0);
    check({tag, "_QB"},  qb,  0);
    check({tag, "_err"}, err, 0);
    check({tag, "_TA"},  ta,  0);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    car_a = 1'b0;
    car_b = 1'b0;
    la    = 2'b10;
    lb    = 2'b00;
    model_clear();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    check("idle_err", err, 0);

    // three cars on A while red
    repeat (3) pulse(0, 2, 4);
    check("three_QA", qa, 3);
    repeat (4) step();
    check("red_hold_QA", qa, 3);

    // drain A on green: one car every DEPART_CYC cycles
    lb = 2'b10;
    la = 2'b00;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 3) check("drain3_QA", qa, 2);
      if (i == 6) check("drain6_QA", qa, 1);
      if (i == 9) check("drain9_QA", qa, 0);
    end
    repeat (5) step();
    check("drained_TA", ta, 0);

    // arrival lands on the departure edge
    la = 2'b10;
    repeat (2) pulse(0, 2, 4);
    la    = 2'b00;
    car_a = 1'b1;
    repeat (3) step();
    check("coincide_QA", qa, 2);
    car_a = 1'b0;
    repeat (3) step();
    check("after_coincide_QA", qa, 1);
    la = 2'b10;

    // saturate B
    repeat (17) pulse(1, 2, 2);
    check("sat_QB", qb, Q_MAX);
    check("sat_ovfB", ovf_b, 1);
    lb = 2'b00;
    repeat (50) step();
    check("sat_drained_QB", qb, 0);
    check("sat_sticky_ovfB", ovf_b, 1);

    // illegal code on A freezes draining and latches err
    lb = 2'b10;
    repeat (2) pulse(0, 2, 4);
    la = 2'b11;
    repeat (6) step();
    check("illegal_hold_QA", qa, 3);
    check("illegal_err", err, 1);

    // reset in the middle of a drain
    la = 2'b00;
    repeat (2) step();
    async_reset("mid_drain");

    // both green for one cycle
    la = 2'b00;
    lb = 2'b00;
    step();
    lb = 2'b10;
    repeat (3) step();
    check("both_green_err", err, 1);
    async_reset("clear_err");

    // randomized traffic and light sequencing
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(2) == 0) car_a = ~car_a;
      if ($urandom_range(2) == 0) car_b = ~car_b;
      if ($urandom_range(7) == 0) la = ($urandom_range(39) == 0) ? 2'b11 : 2'($urandom_range(2));
      if ($urandom_range(7) == 0) lb = ($urandom_range(39) == 0) ? 2'b11 : 2'($urandom_range(2));
      if ($urandom_range(149) == 0) async_reset("rand_rst");
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
